date_counter: RTL and testbench

DATE_COUNTER -- requirements
Module: date_counter

---
 rtl/date_counter_if.sv | 24 ++
 rtl/date_counter.sv | 108 ++++++++++
 tb/tb_date_counter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/date_counter_if.sv
// Date counter control/status bundle: enables, adjust requests and the calendar outputs.
// The master side drives the controls and observes the date.
interface date_counter_if;
    logic        en_1;
    logic        up;
    logic        down;
    logic [2:0]  select_item;
    logic        carry_in;
    logic [4:0]  day_bin;
    logic [3:0]  month_bin;
    logic [11:0] year_bin;
    logic        leap_year;
    logic        carry_out;

    modport master (
        output en_1, up, down, select_item, carry_in,
        input  day_bin, month_bin, year_bin, leap_year, carry_out
    );

    modport slave (
        input  en_1, up, down, select_item, carry_in,
        output day_bin, month_bin, year_bin, leap_year, carry_out
    );
endinterface

// File: rtl/date_counter.sv
// Calendar date counter (day/month/year) advanced by a daily carry pulse, with manual
// up/down adjustment per item and a registered millennium-rollover carry.
module date_counter #(
    parameter logic [2:0]  SELECT_DAY   = 3'b011,
    parameter logic [2:0]  SELECT_MONTH = 3'b100,
    parameter logic [2:0]  SELECT_YEAR  = 3'b101,
    parameter int unsigned YEAR_MIN     = 2000,
    parameter int unsigned YEAR_MAX     = 2999
) (
    input logic          clk_1Hz,
    input logic          rst,
    date_counter_if.slave bus
);

    localparam logic [11:0] YMIN = 12'(YEAR_MIN);
    localparam logic [11:0] YMAX = 12'(YEAR_MAX);

    logic [4:0]  day_q, day_d;
    logic [3:0]  month_q, month_d;
    logic [11:0] year_q, year_d;
    logic        carry_out_q, carry_out_d;

    logic [4:0]  cur_len;
    logic [4:0]  new_len;
    logic        adjust;

    function automatic logic is_leap(input logic [11:0] y);
        return ((y % 12'd4 == 12'd0) && (y % 12'd100 != 12'd0)) || (y % 12'd400 == 12'd0);
    endfunction

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
        logic [4:0] len;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
            4'd2:                    len = leap ? 5'd29 : 5'd28;
            default:                 len = 5'd31;
        endcase
        return len;
    endfunction

    always_comb begin
        day_d       = day_q;
        month_d     = month_q;
        year_d      = year_q;
        carry_out_d = 1'b0;
        cur_len     = month_len(month_q, is_leap(year_q));
        new_len     = cur_len;
        adjust      = (bus.select_item == SELECT_DAY) || (bus.select_item == SELECT_MONTH) ||
                      (bus.select_item == SELECT_YEAR);

        if (adjust) begin
            // carry_in is dropped while adjusting; up wins over down
            if (bus.up || bus.down) begin
                if (bus.select_item == SELECT_DAY) begin
                    if (bus.up) day_d = (day_q >= cur_len) ? 5'd1 : day_q + 5'd1;
                    else        day_d = (day_q <= 5'd1) ? cur_len : day_q - 5'd1;
                end else if (bus.select_item == SELECT_MONTH) begin
                    if (bus.up) month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
                    else        month_d = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
                    new_len = month_len(month_d, is_leap(year_q));
                    if (day_q > new_len) day_d = new_len;
                end else begin
                    if (bus.up) year_d = (year_q >= YMAX) ? YMIN : year_q + 12'd1;
                    else        year_d = (year_q <= YMIN) ? YMAX : year_q - 12'd1;
                    if (month_q == 4'd2 && day_q == 5'd29 && !is_leap(year_d)) day_d = 5'd28;
                end
            end
        end else if (bus.en_1 && bus.carry_in) begin
            if (day_q < cur_len) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d = 5'd1;
                if (month_q < 4'd12) begin
                    month_d = month_q + 4'd1;
                end else begin
                    month_d = 4'd1;
                    if (year_q < YMAX) begin
                        year_d = year_q + 12'd1;
                    end else begin
                        year_d      = YMIN;
                        carry_out_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            day_q       <= 5'd1;
            month_q     <= 4'd1;
            year_q      <= YMIN;
            carry_out_q <= 1'b0;
        end else begin
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign bus.day_bin   = day_q;
    assign bus.month_bin = month_q;
    assign bus.year_bin  = year_q;
    assign bus.leap_year = is_leap(year_q);
    assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_date_counter.sv
// Self-checking bench for date_counter: directed calendar scenarios plus randomized
// stimulus against a plain-arithmetic calendar model.
module tb_date_counter;

    localparam logic [2:0] SEL_DAY   = 3'b011;
    localparam logic [2:0] SEL_MONTH = 3'b100;
    localparam logic [2:0] SEL_YEAR  = 3'b101;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // reference model state
    int md = 1, mm = 1, my = 2000;
    bit mco = 1'b0;

    date_counter_if dif ();

    date_counter dut (
        .clk_1Hz (clk),
        .rst     (rst),
        .bus     (dif)
    );

    always #5 clk = ~clk;

    function automatic bit m_leap(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int m_len(input int m, input int y);
        if (m == 2) return m_leap(y) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    // Apply one cycle of inputs, advance the model, and return #1 after the edge.
    task automatic drive(input bit r, input bit en, input bit u, input bit dn,
                         input logic [2:0] sel, input bit cin);
        int step;
        rst             = r;
        dif.en_1        = en;
        dif.up          = u;
        dif.down        = dn;
        dif.select_item = sel;
        dif.carry_in    = cin;
        mco = 1'b0;
        if (r) begin
            md = 1; mm = 1; my = 2000;
        end else if (sel == SEL_DAY || sel == SEL_MONTH || sel == SEL_YEAR) begin
            if (u || dn) begin
                step = u ? 1 : -1;
                if (sel == SEL_DAY) begin
                    md = ((md - 1 + step + m_len(mm, my)) % m_len(mm, my)) + 1;
                end else if (sel == SEL_MONTH) begin
                    mm = ((mm - 1 + step + 12) % 12) + 1;
                end else begin
                    my = ((my - 2000 + step + 1000) % 1000) + 2000;
                end
                if (md > m_len(mm, my)) md = m_len(mm, my);
            end
        end else if (en && cin) begin
            md = md + 1;
            if (md > m_len(mm, my)) begin
                md = 1;
                mm = mm + 1;
                if (mm > 12) begin
                    mm = 1;
                    my = my + 1;
                    if (my > 2999) begin
                        my  = 2000;
                        mco = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic pulse();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    endtask

    // Reach a date through reset and the adjust controls only.
    task automatic set_date(input int y, input int m, input int d);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        if (y - 2000 <= 500) begin
            for (int i = 0; i < y - 2000; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, SEL_YEAR, 1'b0);
        end else begin
            for (int i = 0; i < 3000 - y; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, SEL_YEAR, 1'b0);
        end
        for (int i = 0; i < m - 1; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, SEL_MONTH, 1'b0);
        for (int i = 0; i < d - 1; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, SEL_DAY, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, SEL_YEAR, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, SEL_MONTH, 1'b1);
        checks++;
        if ({dif.year_bin, dif.month_bin, dif.day_bin, dif.carry_out, dif.leap_year} !==
            {12'd2000, 4'd1, 5'd1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset: got %0d-%0d-%0d co=%0b leap=%0b, want 2000-1-1 co=0 leap=1",
                     dif.year_bin, dif.month_bin, dif.day_bin, dif.carry_out, dif.leap_year);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0);
        checks++;
        if ({dif.year_bin, dif.month_bin, dif.day_bin, dif.carry_out} !==
            {12'd2000, 4'd1, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL hold: got %0d-%0d-%0d co=%0b, want 2000-1-1 co=0",
                     dif.year_bin, dif.month_bin, dif.day_bin, dif.carry_out);
        end
    endtask

    task automatic test_count_month();
        bit seen = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 31; i++) begin
            pulse();
            if (dif.carry_out) seen = 1'b1;
        end
        checks++;
        if ({dif.year_bin, dif.month_bin, dif.day_bin, seen} !==
            {12'd2000, 4'd2, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL count_31: got %0d-%0d-%0d co_seen=%0b, want 2000-2-1 co_seen=0",
                     dif.year_bin, dif.month_bin, dif.day_bin, seen);
        end
    endtask

    task automatic test_leap_feb();
        set_date(2000, 2, 28);
        pulse();
        checks++;
        if ({dif.year_bin, dif.month_bin, dif.day_bin} !== {12'd2000, 4'd2, 5'd29}) begin
            errors++;
            $display("FAIL leap_2000: got %0d-%0d-%0d, want 2000-2-29",
                     dif.year_bin, dif.month_bin, dif.day_bin);
        end
        set_date(2100, 2, 28);
        checks++;
        if (dif.leap_year !== 1'b0) begin
            errors++;
            $display("FAIL leap_flag_2100: got %0b, want 0", dif.leap_year);
        end
        pulse();
        checks++;
        if ({dif.year_bin, dif.month_bin, dif.day_bin} !== {12'd2100, 4'd3, 5'd1}) begin
            errors++;
            $display("FAIL nonleap_2100: got %0d-%0d-%0d, want 2100-3-1",
                     dif.year_bin, dif.month_bin, dif.day_bin);
        end
    endtask

    task automatic test_millennium();
        set_date(2999, 12, 31);
        pulse();
        checks++;
        if ({dif.year_bin, dif.month_bin, dif.day_bin, dif.carry_out} !==
            {12'd2000, 4'd1, 5'd1, 1'b1}) begin
            errors++;
            $display("FAIL millennium: got %0d-%0d-%0d co=%0b, want 2000-1-1 co=1",
                     dif.year_bin, dif.month_bin, dif.day_bin, dif.carry_out);
        end
        idle();
        checks++;
        if (dif.carry_out !== 1'b0) begin
            errors++;
            $display("FAIL carry_one_cycle: got co=%0b, want 0", dif.carry_out);
        end
    endtask

    task automatic test_adjust_clamp();
        set_date(2004, 1, 31);
        drive(1'b0, 1'b0, 1'b1, 1'b0, SEL_MONTH, 1'b0);
        checks++;
        if ({dif.year_bin, dif.month_bin, dif.day_bin} !== {12'd2004, 4'd2, 5'd29}) begin
            errors++;
            $display("FAIL month_clamp: got %0d-%0d-%0d, want 2004-2-29",
                     dif.year_bin, dif.month_bin, dif.day_bin);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, SEL_YEAR, 1'b0);
        checks++;
        if ({dif.year_bin, dif.month_bin, dif.day_bin} !== {12'd2005, 4'd2, 5'd28}) begin
            errors++;
            $display("FAIL year_clamp: got %0d-%0d-%0d, want 2005-2-28",
                     dif.year_bin, dif.month_bin, dif.day_bin);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, SEL_DAY, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, SEL_DAY, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, SEL_DAY, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, SEL_MONTH, 1'b0);
        checks++;
        if ({dif.year_bin, dif.month_bin, dif.day_bin} !== {12'd2005, 4'd1, 5'd27}) begin
            errors++;
            $display("FAIL day_month_down: got %0d-%0d-%0d, want 2005-1-27",
                     dif.year_bin, dif.month_bin, dif.day_bin);
        end
    endtask

    task automatic test_adjust_priority();
        set_date(2001, 4, 30);
        drive(1'b0, 1'b1, 1'b1, 1'b1, SEL_DAY, 1'b1);
        checks++;
        if ({dif.year_bin, dif.month_bin, dif.day_bin, dif.carry_out} !==
            {12'd2001, 4'd4, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL adjust_priority: got %0d-%0d-%0d co=%0b, want 2001-4-1 co=0",
                     dif.year_bin, dif.month_bin, dif.day_bin, dif.carry_out);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        checks++;
        if ({dif.year_bin, dif.month_bin, dif.day_bin} !== {12'd2001, 4'd4, 5'd1}) begin
            errors++;
            $display("FAIL no_deferred_count: got %0d-%0d-%0d, want 2001-4-1",
                     dif.year_bin, dif.month_bin, dif.day_bin);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, SEL_DAY, 1'b0);
        checks++;
        if (dif.day_bin !== 5'd30) begin
            errors++;
            $display("FAIL day_down_wrap: got %0d, want 30", dif.day_bin);
        end
    endtask

    task automatic test_reset_rollover();
        set_date(2999, 12, 31);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
        checks++;
        if ({dif.year_bin, dif.month_bin, dif.day_bin, dif.carry_out} !==
            {12'd2000, 4'd1, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL reset_rollover: got %0d-%0d-%0d co=%0b, want 2000-1-1 co=0",
                     dif.year_bin, dif.month_bin, dif.day_bin, dif.carry_out);
        end
    endtask

    task automatic test_random();
        logic [2:0] sel;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            sel = 3'($urandom_range(0, 7));
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sel,
                  $urandom_range(0, 2) != 0);
            checks++;
            if ({dif.year_bin, dif.month_bin, dif.day_bin, dif.carry_out, dif.leap_year} !==
                {12'(my), 4'(mm), 5'(md), mco, m_leap(my)}) begin
                errors++;
                $display("FAIL random[%0d]: got %0d-%0d-%0d co=%0b leap=%0b, want %0d-%0d-%0d co=%0b leap=%0b",
                         i, dif.year_bin, dif.month_bin, dif.day_bin, dif.carry_out,
                         dif.leap_year, my, mm, md, mco, m_leap(my));
            end
        end
    endtask

    initial begin
        dif.en_1        = 1'b0;
        dif.up          = 1'b0;
        dif.down        = 1'b0;
        dif.select_item = 3'b000;
        dif.carry_in    = 1'b0;
        test_reset();
        test_count_month();
        test_leap_feb();
        test_millennium();
        test_adjust_clamp();
        test_adjust_priority();
        test_reset_rollover();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
